// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and default datapath width
// for the ALU issue/writeback sequencer.
package alu_seq_pkg;
  localparam int SEQ_DATA_W = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MAX = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, a debug read
// port and one synchronous write port, cleared by synchronous reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int DATA_W = SEQ_DATA_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem [NREGS];

  // Reset takes priority so a writeback coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_issue_seq.sv
// Serialized issue/writeback sequencer for the 8-bit combinational ALU.
// Optional done_carry output enabled by defining ALU_ISSUE_SEQ_CARRY_EN.
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int NREGS  = 4,
  parameter int DATA_W = SEQ_DATA_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [AW-1:0]     in_ra,
  input  logic [AW-1:0]     in_rb,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [3:0]        alu_opS,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic              done_zero,
  output logic              done_illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_SEQ_CARRY_EN
  ,
  output logic              done_carry
`endif
);
  state_t            state, state_nxt;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic [AW-1:0]     rd_p0;
  logic              illegal_p0;
  logic              accept;
  logic              wb_en;

`ifdef ALU_ISSUE_SEQ_CARRY_EN
  function automatic logic carry_of(input logic [3:0] op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  return sum[DATA_W];
      OP_SUB:  return (a < b);
      OP_SHL:  return a[DATA_W-1];
      OP_SHR:  return a[0];
      default: return 1'b0;
    endcase
  endfunction
`endif

  alu_seq_regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_ra),
    .ra_data  (ra_data),
    .rb_addr  (in_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wa       (rd_p0),
    .wd       (done_result)
  );

  assign in_ready     = (state == IDLE) && !rst;
  assign accept       = in_valid && in_ready;
  assign done_valid   = (state == WB) && !rst;
  assign done_illegal = illegal_p0;
  assign wb_en        = (state == WB) && !illegal_p0 && (alu_opS != OP_NOP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_opA     <= '0;
      alu_opB     <= '0;
      alu_opS     <= '0;
      rd_p0       <= '0;
      illegal_p0  <= 1'b0;
      done_result <= '0;
      done_zero   <= 1'b0;
`ifdef ALU_ISSUE_SEQ_CARRY_EN
      done_carry  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // Accept boundary: operands read from the register file at issue time
      if (accept) begin
        alu_opA    <= ra_data;
        alu_opB    <= in_imm_en ? in_imm : rb_data;
        alu_opS    <= in_op;
        rd_p0      <= in_rd;
        illegal_p0 <= (in_op > OP_MAX);
      end
      // EXEC boundary: ALU output has settled on the latched operands
      if (state == EXEC) begin
        done_result <= alu_result;
        done_zero   <= (alu_result == '0);
`ifdef ALU_ISSUE_SEQ_CARRY_EN
        done_carry  <= carry_of(alu_opS, alu_opA, alu_opB);
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a behavioural model of the ALU.
module tb_alu_issue_seq;
  import alu_seq_pkg::*;

  localparam int AW = 2;

  typedef struct {
    logic [7:0] res;
    logic       il;
    logic       cy;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_imm_en;
  logic [3:0] in_op;
  logic [AW-1:0] in_ra, in_rb, in_rd, dbg_addr;
  logic [7:0] in_imm, alu_opA, alu_opB, alu_result, done_result, dbg_data;
  logic [3:0] alu_opS;
  logic       done_valid, done_zero, done_illegal;
`ifdef ALU_ISSUE_SEQ_CARRY_EN
  logic       done_carry;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  logic [7:0] mregs [4];
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_seq #(.NREGS(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opS(alu_opS),
    .alu_result(alu_result),
    .done_valid(done_valid), .done_result(done_result),
    .done_zero(done_zero), .done_illegal(done_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_SEQ_CARRY_EN
    , .done_carry(done_carry)
`endif
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return ~a;
      4'd7: return {a[6:0], 1'b0};
      4'd8: return {1'b0, a[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic carry_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd1: return s[8];
      4'd2: return a < b;
      4'd7: return a[7];
      4'd8: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_opS, alu_opA, alu_opB);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done_valid === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("result", done_result, mon_e.res);
        chk("zero", done_zero, mon_e.res == 8'h00);
        chk("illegal", done_illegal, mon_e.il);
        chk("latency", cyc - mon_e.acc, 1);
`ifdef ALU_ISSUE_SEQ_CARRY_EN
        chk("carry", done_carry, mon_e.cy);
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] op, input int ra, input int rb, input int rd,
                       input logic ie, input logic [7:0] imm, output int acc);
    exp_t e;
    logic [7:0] a, b;
    int k;
    in_op = op; in_ra = ra[AW-1:0]; in_rb = rb[AW-1:0]; in_rd = rd[AW-1:0];
    in_imm_en = ie; in_imm = imm; in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
      return;
    end
    a = mregs[ra];
    b = ie ? imm : mregs[rb];
    e.res = alu_f(op, a, b);
    e.il = (op > 4'd8);
    e.cy = carry_f(op, a, b);
    if (!e.il && op != 4'd0) mregs[rd] = e.res;
    @(posedge clk);
    @(negedge clk);
    e.acc = cyc;
    acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
      k++;
    end
    if (k >= 20) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reg(input int i, input logic [7:0] exp);
    dbg_addr = i[AW-1:0];
    #1;
    chk($sformatf("r%0d", i), dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, d0;
    rst = 1'b1; in_valid = 1'b0; in_op = 0; in_ra = 0; in_rb = 0; in_rd = 0;
    in_imm_en = 1'b0; in_imm = 0; dbg_addr = 0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_opA", alu_opA, 0);
    chk("rst_opS", alu_opS, 0);
    chk("rst_done_result", done_result, 0);
    for (int i = 0; i < 4; i++) chk_reg(i, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    issue(OP_ADD, 0, 0, 1, 1'b1, 8'h05, a0); drain(); chk_reg(1, 8'h05);
    issue(OP_ADD, 1, 0, 2, 1'b1, 8'h02, a0); drain(); chk_reg(2, 8'h07);
    issue(OP_SUB, 1, 0, 3, 1'b1, 8'h07, a0); drain(); chk_reg(3, 8'hFE);
    issue(OP_OR,  0, 0, 0, 1'b1, 8'h81, a0); drain(); chk_reg(0, 8'h81);
    issue(OP_SHL, 0, 0, 3, 1'b0, 8'h00, a0); drain(); chk_reg(3, 8'h02);
    issue(OP_XOR, 1, 1, 1, 1'b0, 8'h00, a0); drain(); chk_reg(1, 8'h00);
    issue(OP_NOP, 0, 0, 2, 1'b0, 8'h00, a0); drain(); chk_reg(2, 8'h07);
    issue(4'd12,  2, 2, 2, 1'b0, 8'h00, a0); drain(); chk_reg(2, 8'h07);
    issue(OP_AND, 2, 0, 3, 1'b1, 8'h0F, a0); drain(); chk_reg(3, 8'h07);

    // Back-to-back with in_valid held high throughout
    d0 = n_done;
    issue(OP_NOT, 2, 0, 0, 1'b0, 8'h00, a1);
    issue(OP_SHR, 0, 0, 1, 1'b0, 8'h00, a2);
    issue(OP_ADD, 1, 0, 2, 1'b0, 8'h00, a3);
    drain();
    chk("b2b_gap1", a2 - a1, 3);
    chk("b2b_gap2", a3 - a2, 3);
    chk("b2b_count", n_done - d0, 3);
    chk_reg(0, 8'hF8); chk_reg(1, 8'h7C); chk_reg(2, 8'h74);

    // 8-bit wrap-around to zero
    issue(OP_OR,  3, 0, 3, 1'b1, 8'hFF, a0); drain();
    issue(OP_ADD, 3, 0, 3, 1'b1, 8'h01, a0); drain(); chk_reg(3, 8'h00);

    // Reset while the ADD is in EXEC
    d0 = n_done;
    issue(OP_ADD, 0, 0, 1, 1'b1, 8'h03, a0);
    in_valid = 1'b0;
    void'(q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done_valid", done_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_reg(i, 8'h00);
      mregs[i] = 8'h00;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", in_ready, 1);
    chk("midrst_no_done", n_done - d0, 0);
    issue(OP_ADD, 0, 0, 1, 1'b1, 8'h09, a0); drain(); chk_reg(1, 8'h09);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
